fir_coef_bank: RTL and testbench
================================

# fir_coef_bank

Double-buffered coefficient store feeding the `iv_weight` inputs of the FIR tap chain. Host-side writes land in a shadow bank through a valid/ready port. A commit request copies the shadow bank into the active bank only on a sample-enable edge, so weights never change in the middle of a sample. The active bank drives all taps in parallel as one flat vector.

## Interface
- `DATA_WIDTH`, 24, coefficient width, signed Q1.(DATA_WIDTH-1); must match the tap chain.
- `NUM_TAPS`, 8, number of coefficients/taps, range 2..256.
- `ADDR_WIDTH`, 3, write address width; must be ≥ clog2(NUM_TAPS).

Ports:
- `i_clk`  in  1  single clock; all logic on the rising edge.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_en`  in  1  sample strobe; the same signal that enables the tap chain registers.
- `i_wr_valid`  in  1  write request.
- `iv_wr_addr`  in  ADDR_WIDTH  tap index to write.
- `iv_wr_data`  in  DATA_WIDTH  signed coefficient.
- `o_wr_ready`  out  1  write accepted when high together with `i_wr_valid`.
- `i_commit`  in  1  request to apply the shadow bank.
- `o_commit_pending`  out  1  commit requested, swap not yet done.
- `ov_weights`  out  NUM_TAPS*DATA_WIDTH  active bank; tap k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `o_swapped`  out  1  one-cycle pulse after each swap.
- `ov_swap_cnt`  out  8  count of completed swaps, wraps 255→0.
- `o_addr_err`  out  1  one-cycle pulse on a write to an address ≥ NUM_TAPS.

## Operation
- Two states:
  - IDLE: `o_wr_ready`=1, `o_commit_pending`=0.
  - PENDING: `o_wr_ready`=0, `o_commit_pending`=1.
- `o_wr_ready` and `o_commit_pending` are decoded combinationally from the state register.
- Write handshake: a write occurs when `i_wr_valid` && `o_wr_ready`.
  - If the address is below NUM_TAPS, `shadow[addr]` <= data.
  - Otherwise the write is dropped and `o_addr_err`=1 on the next cycle. The handshake still completes.
- In PENDING, `i_wr_valid` is ignored; no write occurs and no error is flagged.
- IDLE → PENDING on `i_commit`=1.
- PENDING → IDLE at the first edge where `i_en`=1. At that edge:
  - `active` <= `shadow` (entire bank at once),
  - `o_swapped`=1 for the following cycle,
  - `ov_swap_cnt` increments.
- `i_commit` while in PENDING is ignored; there is no queued second commit.
- Shadow contents are kept after a swap. Partial edits followed by a commit therefore carry the unedited entries forward.
- `ov_weights` is driven straight from the active registers, with no combinational path from any input.
- No arithmetic on coefficients. Values are stored and forwarded bit-exact.

## Timing
- Reset (i_rst high at an edge) sets:
  - state IDLE;
  - both banks: tap 0 = 2^(DATA_WIDTH-1)-1 (≈1.0, pass-through), all other taps = 0;
  - `o_swapped`=0, `o_addr_err`=0, `ov_swap_cnt`=0.
- Outputs right after reset: `o_wr_ready`=1, `o_commit_pending`=0.
- Write latency: the shadow entry updates at the accepting edge. It is visible on `ov_weights` only after a swap.
- Commit latency: if `i_commit` is seen at edge N and the next `i_en` arrives at edge M > N:
  - `active` updates at M;
  - `o_swapped` is high during cycle M→M+1.
- Same-cycle write and commit in IDLE: the write is applied to shadow, and the commit includes it.
- Same-cycle `i_commit` and `i_en` in IDLE: go to PENDING only. The swap waits for the next `i_en`, never the same edge.
- `i_en` with no pending commit has no effect.
- Reset during PENDING returns to IDLE with reset values in both banks. The pending commit is discarded and no `o_swapped` pulse is produced.
- Reset takes priority over every other event in the same cycle.
- `ov_swap_cnt` at 255 followed by a swap reads 0.

## Test plan
- Reset, then hold `i_en`=1 → `ov_weights` tap0=0x7FFFFF, taps1–7=0, `o_wr_ready`=1, `ov_swap_cnt`=0.
- Write taps 0–7 with 0x100000·(k+1), commit, pulse `i_en` 3 cycles later:
  - `ov_weights` unchanged until the `i_en` edge, then equal to the written values;
  - `o_swapped` high for exactly 1 cycle;
  - `ov_swap_cnt`=1.
- Commit, then drive `i_wr_valid` (addr 2, data 0x7FFFFF) for 5 cycles with `i_en`=0 → `o_wr_ready`=0 throughout, shadow[2] unchanged; after `i_en`, `o_wr_ready`=1.
- Write addr 9 with NUM_TAPS=8 → `o_addr_err` 1-cycle pulse, no bank change. Write addr 3 with 0xFFFFFF in the same cycle as `i_commit` → active tap3=0xFFFFFF after the next `i_en`.
- Commit, then `i_rst`=1 for 1 cycle before any `i_en` → no swap, `ov_weights` back to reset values, `o_commit_pending`=0.
- 256 commit/`i_en` cycles → `ov_swap_cnt` reads 0, and 256 `o_swapped` pulses are counted.

Source files
------------

// File: rtl/fir_coef_bank.sv
// -----------------------------------------------------------------------------
// fir_coef_bank
//
// Double-buffered coefficient store for the FIR tap chain. The host writes
// single coefficients into a shadow bank over a valid/ready port. A commit
// request arms a swap. The swap copies the whole shadow bank into the active
// bank on the next sample strobe, so the taps never see a half-updated set.
//
// Parameters:
//    DATA_WIDTH  coefficient width, signed Q1.(DATA_WIDTH-1)
//    NUM_TAPS    number of coefficients (2..256)
//    ADDR_WIDTH  write address width, >= clog2(NUM_TAPS)
//
// Ports:
//    i_clk, i_rst        clock, synchronous active-high reset
//    i_en                sample strobe shared with the tap chain
//    i_wr_valid          write request
//    iv_wr_addr          tap index to write
//    iv_wr_data          coefficient to write
//    o_wr_ready          write accepted (IDLE only)
//    i_commit            request to apply the shadow bank
//    o_commit_pending    commit armed, swap not yet done
//    ov_weights          active bank, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
//    o_swapped           one-cycle pulse after each swap
//    ov_swap_cnt         completed swaps, wraps 255 -> 0
//    o_addr_err          one-cycle pulse after a write to an address >= NUM_TAPS
// -----------------------------------------------------------------------------
module fir_coef_bank #(
   parameter int DATA_WIDTH = 24,
   parameter int NUM_TAPS   = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_en,
   input  logic                           i_wr_valid,
   input  logic [ADDR_WIDTH-1:0]          iv_wr_addr,
   input  logic [DATA_WIDTH-1:0]          iv_wr_data,
   output logic                           o_wr_ready,
   input  logic                           i_commit,
   output logic                           o_commit_pending,
   output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
   output logic                           o_swapped,
   output logic [7:0]                     ov_swap_cnt,
   output logic                           o_addr_err
);

   localparam int BANK_W = NUM_TAPS * DATA_WIDTH;

   localparam logic [0:0] ST_IDLE    = 1'b0;
   localparam logic [0:0] ST_PENDING = 1'b1;

   // Reset bank: tap 0 just below +1.0 so the filter passes samples through,
   // every other tap zero.
   localparam logic [BANK_W-1:0] RESET_BANK =
      {{(BANK_W-DATA_WIDTH){1'b0}}, 1'b0, {(DATA_WIDTH-1){1'b1}}};

   logic [0:0]        state_q,    state_d;
   logic [BANK_W-1:0] shadow_q,   shadow_d;
   logic [BANK_W-1:0] active_q,   active_d;
   logic              swapped_q,  swapped_d;
   logic              addr_err_q, addr_err_d;
   logic [7:0]        swap_cnt_q, swap_cnt_d;

   logic              addr_in_range_s;

   assign addr_in_range_s = (32'(iv_wr_addr) < 32'(NUM_TAPS));

   // Next-state computation for the handshake FSM, both banks and status flags.
   always_comb begin
      state_d    = state_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      swapped_d  = 1'b0;
      addr_err_d = 1'b0;
      swap_cnt_d = swap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            // An out-of-range write still completes the handshake; it is
            // dropped and flagged.
            if (i_wr_valid) begin
               if (addr_in_range_s) begin
                  for (int k = 0; k < NUM_TAPS; k++) begin
                     if (32'(iv_wr_addr) == 32'(k)) begin
                        shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = iv_wr_data;
                     end else begin
                        shadow_d[k*DATA_WIDTH +: DATA_WIDTH] = shadow_q[k*DATA_WIDTH +: DATA_WIDTH];
                     end
                  end
               end else begin
                  addr_err_d = 1'b1;
               end
            end else begin
               shadow_d = shadow_q;
            end
            // i_en in the commit cycle is deliberately not a swap edge: the
            // swap always waits for a later strobe.
            if (i_commit) begin
               state_d = ST_PENDING;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_PENDING: begin
            if (i_en) begin
               active_d   = shadow_q;
               swapped_d  = 1'b1;
               swap_cnt_d = swap_cnt_q + 8'd1;
               state_d    = ST_IDLE;
            end else begin
               state_d    = ST_PENDING;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         shadow_q   <= RESET_BANK;
         active_q   <= RESET_BANK;
         swapped_q  <= 1'b0;
         addr_err_q <= 1'b0;
         swap_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         swapped_q  <= swapped_d;
         addr_err_q <= addr_err_d;
         swap_cnt_q <= swap_cnt_d;
      end
   end

   // Handshake outputs are decoded from the state flop only, so they carry no
   // path from any input.
   assign o_wr_ready       = (state_q == ST_IDLE);
   assign o_commit_pending = (state_q == ST_PENDING);

   assign ov_weights  = active_q;
   assign o_swapped   = swapped_q;
   assign ov_swap_cnt = swap_cnt_q;
   assign o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_fir_coef_bank.sv
// -----------------------------------------------------------------------------
// tb_fir_coef_bank
//
// Self-checking bench for fir_coef_bank (8 taps x 24 bits, 4-bit address so
// that out-of-range writes can be exercised). Expected active banks are pushed
// into a scoreboard queue when a commit is driven and popped when the DUT
// signals the swap.
// -----------------------------------------------------------------------------
module tb_fir_coef_bank;

   localparam int DW = 24;
   localparam int NT = 8;
   localparam int AW = 4;
   localparam int BW = NT * DW;

   localparam logic [BW-1:0] RST_BANK = {168'd0, 24'h7FFFFF};

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          wr_valid = 1'b0;
   logic [AW-1:0] wr_addr = 4'd0;
   logic [DW-1:0] wr_data = 24'd0;
   logic          wr_ready;
   logic          commit = 1'b0;
   logic          commit_pending;
   logic [BW-1:0] weights;
   logic          swapped;
   logic [7:0]    swap_cnt;
   logic          addr_err;

   int n_vec = 0;
   int n_bad = 0;

   logic [BW-1:0] exp_shadow;
   logic [BW-1:0] exp_active;
   logic [BW-1:0] sb_q[$];
   logic [BW-1:0] sb_exp;

   fir_coef_bank #(.DATA_WIDTH(DW), .NUM_TAPS(NT), .ADDR_WIDTH(AW)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_en             (en),
      .i_wr_valid       (wr_valid),
      .iv_wr_addr       (wr_addr),
      .iv_wr_data       (wr_data),
      .o_wr_ready       (wr_ready),
      .i_commit         (commit),
      .o_commit_pending (commit_pending),
      .ov_weights       (weights),
      .o_swapped        (swapped),
      .ov_swap_cnt      (swap_cnt),
      .o_addr_err       (addr_err)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs, let the edge happen, then settle just after it.
   task automatic cyc(input logic e, input logic wv, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic cm, input logic rs);
      en = e; wr_valid = wv; wr_addr = a; wr_data = d; commit = cm; rst = rs;
      @(posedge clk);
      #1;
   endtask

   // Pop the expected bank for a swap the DUT just announced and compare.
   task automatic sb_pop_check(input string name);
      n_vec++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL %s: swap seen with empty scoreboard", name);
      end else begin
         sb_exp = sb_q.pop_front();
         if (weights !== sb_exp) begin
            n_bad++;
            $display("FAIL %s: weights %h expected %h", name, weights, sb_exp);
         end
      end
   endtask

   task automatic test_reset;
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
      exp_shadow = RST_BANK;
      exp_active = RST_BANK;
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (weights !== RST_BANK) begin
         n_bad++; $display("FAIL reset_weights: got %h expected %h", weights, RST_BANK);
      end
      n_vec++;
      if (wr_ready !== 1'b1 || commit_pending !== 1'b0) begin
         n_bad++; $display("FAIL reset_hs: ready=%b pending=%b expected 1/0", wr_ready, commit_pending);
      end
      n_vec++;
      if (swap_cnt !== 8'd0 || swapped !== 1'b0 || addr_err !== 1'b0) begin
         n_bad++; $display("FAIL reset_status: cnt=%0d swp=%b err=%b expected 0/0/0", swap_cnt, swapped, addr_err);
      end
   endtask

   task automatic test_write_commit;
      logic [DW-1:0] v;
      for (int k = 0; k < NT; k++) begin
         v = 24'(32'h100000 * (k + 1));
         n_vec++;
         if (wr_ready !== 1'b1) begin
            n_bad++; $display("FAIL wc_ready: tap %0d ready=%b expected 1", k, wr_ready);
         end
         cyc(1'b0, 1'b1, 4'(k), v, 1'b0, 1'b0);
         exp_shadow[k*DW +: DW] = v;
      end
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
      sb_q.push_back(exp_shadow);
      n_vec++;
      if (commit_pending !== 1'b1 || wr_ready !== 1'b0) begin
         n_bad++; $display("FAIL wc_pending: pending=%b ready=%b expected 1/0", commit_pending, wr_ready);
      end
      for (int i = 0; i < 2; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
         n_vec++;
         if (weights !== exp_active || swapped !== 1'b0) begin
            n_bad++; $display("FAIL wc_hold: weights %h swp=%b expected %h/0", weights, swapped, exp_active);
         end
      end
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (swapped !== 1'b1) begin
         n_bad++; $display("FAIL wc_swapped: got %b expected 1", swapped);
      end
      if (swapped === 1'b1) sb_pop_check("wc_weights");
      exp_active = exp_shadow;
      n_vec++;
      if (swap_cnt !== 8'd1 || commit_pending !== 1'b0) begin
         n_bad++; $display("FAIL wc_cnt: cnt=%0d pending=%b expected 1/0", swap_cnt, commit_pending);
      end
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (swapped !== 1'b0) begin
         n_bad++; $display("FAIL wc_pulse_len: got %b expected 0", swapped);
      end
   endtask

   task automatic test_blocked_writes;
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
      sb_q.push_back(exp_shadow);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (wr_ready !== 1'b0) begin
            n_bad++; $display("FAIL blk_ready: cycle %0d ready=%b expected 0", i, wr_ready);
         end
         cyc(1'b0, 1'b1, 4'd2, 24'h7FFFFF, 1'b0, 1'b0);
         n_vec++;
         if (addr_err !== 1'b0) begin
            n_bad++; $display("FAIL blk_err: cycle %0d err=%b expected 0", i, addr_err);
         end
      end
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      sb_pop_check("blk_shadow2");
      exp_active = exp_shadow;
      n_vec++;
      if (wr_ready !== 1'b1 || swap_cnt !== 8'd2) begin
         n_bad++; $display("FAIL blk_after: ready=%b cnt=%0d expected 1/2", wr_ready, swap_cnt);
      end
   endtask

   task automatic test_addr_err;
      cyc(1'b0, 1'b1, 4'd9, 24'h123456, 1'b0, 1'b0);
      n_vec++;
      if (addr_err !== 1'b1 || wr_ready !== 1'b1) begin
         n_bad++; $display("FAIL aerr_pulse: err=%b ready=%b expected 1/1", addr_err, wr_ready);
      end
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (addr_err !== 1'b0 || weights !== exp_active) begin
         n_bad++; $display("FAIL aerr_clear: err=%b weights %h expected 0/%h", addr_err, weights, exp_active);
      end
      // Write and commit in the same cycle: the write must ride along.
      cyc(1'b0, 1'b1, 4'd3, 24'hFFFFFF, 1'b1, 1'b0);
      exp_shadow[3*DW +: DW] = 24'hFFFFFF;
      sb_q.push_back(exp_shadow);
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      sb_pop_check("aerr_tap3");
      exp_active = exp_shadow;
      n_vec++;
      if (weights[3*DW +: DW] !== 24'hFFFFFF || swap_cnt !== 8'd3) begin
         n_bad++; $display("FAIL aerr_tap3_cnt: tap3=%h cnt=%0d expected ffffff/3", weights[3*DW +: DW], swap_cnt);
      end
   endtask

   task automatic test_commit_en_same_cycle;
      exp_shadow[5*DW +: DW] = 24'hABCDEF;
      cyc(1'b0, 1'b1, 4'd5, 24'hABCDEF, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
      sb_q.push_back(exp_shadow);
      n_vec++;
      if (swapped !== 1'b0 || commit_pending !== 1'b1 || weights !== exp_active) begin
         n_bad++; $display("FAIL same_edge: swp=%b pend=%b weights %h", swapped, commit_pending, weights);
      end
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (swapped !== 1'b1 || swap_cnt !== 8'd4) begin
         n_bad++; $display("FAIL same_next: swp=%b cnt=%0d expected 1/4", swapped, swap_cnt);
      end
      sb_pop_check("same_weights");
      exp_active = exp_shadow;
   endtask

   task automatic test_reset_pending;
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
      // Reset coincides with a strobe; reset must win and drop the commit.
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
      exp_shadow = RST_BANK;
      exp_active = RST_BANK;
      n_vec++;
      if (swapped !== 1'b0 || commit_pending !== 1'b0 || weights !== RST_BANK || swap_cnt !== 8'd0) begin
         n_bad++; $display("FAIL rstp_state: swp=%b pend=%b cnt=%0d weights %h", swapped, commit_pending, swap_cnt, weights);
      end
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      n_vec++;
      if (swapped !== 1'b0 || weights !== RST_BANK) begin
         n_bad++; $display("FAIL rstp_noswap: swp=%b weights %h", swapped, weights);
      end
      // The shadow must also be back at reset values.
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
      sb_q.push_back(exp_shadow);
      cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
      sb_pop_check("rstp_shadow");
   endtask

   task automatic test_wrap;
      int pulses;
      pulses = 0;
      cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++) begin
         cyc(1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 1'b0);
         if (swapped === 1'b1) pulses++;
         cyc(1'b1, 1'b0, 4'd0, 24'd0, 1'b0, 1'b0);
         if (swapped === 1'b1) pulses++;
         if (i == 254) begin
            n_vec++;
            if (swap_cnt !== 8'd255) begin
               n_bad++; $display("FAIL wrap_255: cnt=%0d expected 255", swap_cnt);
            end
         end
      end
      n_vec++;
      if (swap_cnt !== 8'd0) begin
         n_bad++; $display("FAIL wrap_cnt: cnt=%0d expected 0", swap_cnt);
      end
      n_vec++;
      if (pulses != 256) begin
         n_bad++; $display("FAIL wrap_pulses: counted %0d expected 256", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_write_commit();
      test_blocked_writes();
      test_addr_err();
      test_commit_en_same_cycle();
      test_reset_pending();
      test_wrap();
      n_vec++;
      if (sb_q.size() != 0) begin
         n_bad++; $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
